entropy_sample_reader: RTL and testbench

- Consumer end of the online-health-test sample FIFO; the health test enqueues SAMPLE_SIZE-bit checked samples and raises valid.
- This block issues the deque pulse, captures one sample and streams it out as WORD_W-bit words over a ready/valid interface to the downstream conditioner/SPI readout.
- Enforces the permanent-fail lockout on the read side and counts delivered samples.

---
 rtl/entropy_sample_reader_if.sv | 55 +++++
 rtl/entropy_sample_reader.sv | 214 +++++++++++++++++++++
 tb/tb_entropy_sample_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/entropy_sample_reader_if.sv
// ---------------------------------------------------------------------------
// entropy_sample_reader_if
//   Bundles the sample-FIFO read side and the word-stream output of the
//   entropy sample reader.
//
//   FIFO side   : src_valid, src_empty, src_perm_fail, src_rdata (to reader)
//                 deque (from reader)
//   Stream side : out_data, out_valid, out_last (from reader)
//                 out_ready (to reader)
//
//   Modports
//     master : the reader (drives deque and the output stream)
//     slave  : its environment (FIFO / health test and downstream sink)
// ---------------------------------------------------------------------------
interface entropy_sample_reader_if #(
    parameter int unsigned SAMPLE_SIZE = 256,
    parameter int unsigned WORD_W      = 32
);

    logic                   src_valid;
    logic                   src_empty;
    logic                   src_perm_fail;
    logic [SAMPLE_SIZE-1:0] src_rdata;
    logic                   deque;

    logic [WORD_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;

    modport master (
        input  src_valid,
        input  src_empty,
        input  src_perm_fail,
        input  src_rdata,
        output deque,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport slave (
        output src_valid,
        output src_empty,
        output src_perm_fail,
        output src_rdata,
        input  deque,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );

endinterface

// File: rtl/entropy_sample_reader.sv
// ---------------------------------------------------------------------------
// entropy_sample_reader
//   Consumer end of the online-health-test sample FIFO. Pops one checked
//   sample, captures it, and streams it MSB word first over a ready/valid
//   interface. A permanent health-test failure locks the reader out until
//   reset. Fully delivered samples are counted (saturating).
//
//   Ports
//     clk, rst      : clock, asynchronous active-high reset
//     bus (master)  : FIFO read side (src_*, deque) and output stream
//                     (out_data, out_valid, out_ready, out_last)
//     lockout       : sticky permanent-fail flag
//     sample_count  : samples fully delivered, saturating
//     repeat_drop   : one-cycle pulse when a captured sample repeats the
//                     previously delivered one (only with the option below)
//
//   Optional feature (define ENTROPY_READER_REPEAT_CHK_EN):
//     keeps a copy of the last delivered sample and drops a captured sample
//     that is identical to it instead of streaming it.
//
//   SAMPLE_SIZE must be a multiple of WORD_W.
// ---------------------------------------------------------------------------
module entropy_sample_reader #(
    parameter int unsigned SAMPLE_SIZE = 256,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    entropy_sample_reader_if.master bus,
    output logic                   lockout,
    output logic [CNT_W-1:0]       sample_count
`ifdef ENTROPY_READER_REPEAT_CHK_EN
    ,
    output logic                   repeat_drop
`endif
);

    localparam int unsigned NUM_WORDS = SAMPLE_SIZE / WORD_W;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_FAIL   = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic                   deque_q;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic [WORD_W-1:0]      out_data_q;
    logic [SAMPLE_SIZE-1:0] sample_buf_q;
    logic [IDX_W-1:0]       idx_q;

    // Decode produced by the output process, consumed by the datapath
    logic                   deque_d;
    logic                   capture;
    logic                   advance;
    logic                   finish;
    logic                   handshake;
    logic                   repeat_hit;

    // Word i of a sample, counted from the most significant end
    function automatic logic [WORD_W-1:0] word_at(
        input logic [SAMPLE_SIZE-1:0] s,
        input logic [IDX_W-1:0]       i
    );
        logic [SAMPLE_SIZE-1:0] shifted;
        shifted = s << (WORD_W * 32'(i));
        return shifted[SAMPLE_SIZE-1 -: WORD_W];
    endfunction

    assign handshake = out_valid_q && bus.out_ready;

`ifdef ENTROPY_READER_REPEAT_CHK_EN
    logic [SAMPLE_SIZE-1:0] last_sample_q;
    logic                   drop;
    logic                   repeat_drop_q;

    assign repeat_hit  = (bus.src_rdata == last_sample_q);
    assign repeat_drop = repeat_drop_q;
`else
    assign repeat_hit  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a permanent failure overrides every state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // deque_q high means the pop is in flight; data arrives next cycle
            S_IDLE:   if (deque_q) state_d = S_WAIT;
            S_WAIT:   state_d = repeat_hit ? S_IDLE : S_STREAM;
            S_STREAM: if (handshake && (idx_q == LAST_IDX)) state_d = S_IDLE;
            S_FAIL:   state_d = S_FAIL;
            default:  state_d = S_IDLE;
        endcase
        if (bus.src_perm_fail) begin
            state_d = S_FAIL;
        end
    end

    // Output/control decode for the registered datapath
    always_comb begin
        deque_d = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
`ifdef ENTROPY_READER_REPEAT_CHK_EN
        drop    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                // !deque_q keeps the strobe to a single cycle per sample
                deque_d = bus.src_valid && !bus.src_empty && !deque_q
                          && !bus.src_perm_fail;
            end
            S_WAIT: begin
`ifdef ENTROPY_READER_REPEAT_CHK_EN
                drop    = repeat_hit;
`endif
                capture = !repeat_hit;
            end
            S_STREAM: begin
                if (handshake) begin
                    finish  = (idx_q == LAST_IDX);
                    advance = (idx_q != LAST_IDX);
                end
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deque_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            sample_buf_q <= '0;
            idx_q        <= '0;
            lockout      <= 1'b0;
            sample_count <= '0;
        end else if (bus.src_perm_fail || (state_q == S_FAIL)) begin
            deque_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            sample_buf_q <= '0;
            idx_q        <= '0;
            lockout      <= 1'b1;
            // A last-word handshake in the failing cycle was delivered
            if (finish && (sample_count != CNT_MAX)) begin
                sample_count <= sample_count + CNT_W'(1);
            end
        end else begin
            deque_q <= deque_d;
            if (capture) begin
                sample_buf_q <= bus.src_rdata;
                idx_q        <= '0;
                out_data_q   <= bus.src_rdata[SAMPLE_SIZE-1 -: WORD_W];
                out_last_q   <= (NUM_WORDS == 1);
                out_valid_q  <= 1'b1;
            end else if (advance) begin
                idx_q        <= idx_q + IDX_W'(1);
                out_data_q   <= word_at(sample_buf_q, idx_q + IDX_W'(1));
                out_last_q   <= ((idx_q + IDX_W'(1)) == LAST_IDX);
            end else if (finish) begin
                idx_q        <= '0;
                out_valid_q  <= 1'b0;
                out_last_q   <= 1'b0;
                if (sample_count != CNT_MAX) begin
                    sample_count <= sample_count + CNT_W'(1);
                end
            end
        end
    end

`ifdef ENTROPY_READER_REPEAT_CHK_EN
    // Copy of the last delivered sample and the drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sample_q <= '0;
            repeat_drop_q <= 1'b0;
        end else begin
            repeat_drop_q <= drop && !bus.src_perm_fail;
            if (finish) begin
                last_sample_q <= sample_buf_q;
            end
        end
    end
`endif

    assign bus.deque     = deque_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_entropy_sample_reader.sv
// ---------------------------------------------------------------------------
// tb_entropy_sample_reader
//   Self-checking bench for entropy_sample_reader. A small FIFO model feeds
//   samples (read data valid the cycle after deque); expected words are
//   queued when a sample is pushed and compared as handshakes happen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_entropy_sample_reader;

    localparam int unsigned SAMPLE_SIZE = 256;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned NUM_WORDS   = SAMPLE_SIZE / WORD_W;
    localparam logic [SAMPLE_SIZE-1:0] FILLER = {8{32'hA5C3_5A3C}};

    logic clk;
    logic rst;
    logic lockout;
    logic [CNT_W-1:0] sample_count;
`ifdef ENTROPY_READER_REPEAT_CHK_EN
    logic repeat_drop;
`endif

    entropy_sample_reader_if #(.SAMPLE_SIZE(SAMPLE_SIZE), .WORD_W(WORD_W)) bus ();

    entropy_sample_reader #(
        .SAMPLE_SIZE(SAMPLE_SIZE),
        .WORD_W     (WORD_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .lockout     (lockout),
        .sample_count(sample_count)
`ifdef ENTROPY_READER_REPEAT_CHK_EN
        ,
        .repeat_drop (repeat_drop)
`endif
    );

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int deq_cnt = 0;
    int drop_cnt = 0;

    logic [SAMPLE_SIZE-1:0] fifo_q[$];
    logic [WORD_W:0]        exp_q[$];
    bit                     deq_pending = 0;
    bit                     stall_prev = 0;
    logic [WORD_W:0]        stall_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // FIFO model: pop on deque, present the popped sample the next cycle
    always @(negedge clk) begin
        if (!rst && bus.deque) begin
            deq_cnt++;
            deq_pending = 1'b1;
            tests++;
            if (bus.src_empty || lockout) begin
                fails++;
                $display("FAIL deque_gate: deque=1 with src_empty=%0b lockout=%0b, required no deque",
                         bus.src_empty, lockout);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (deq_pending && fifo_q.size() > 0) begin
            bus.src_rdata = fifo_q.pop_front();
        end else begin
            bus.src_rdata = FILLER;
        end
        deq_pending   = 1'b0;
        bus.src_empty = (fifo_q.size() == 0);
    end

    // Scoreboard monitor: compare each handshake, check stall stability
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && bus.out_valid) begin
                tests++;
                if ({bus.out_last, bus.out_data} !== stall_word) begin
                    fails++;
                    $display("FAIL stall_hold: got last=%0b data=%h, required last=%0b data=%h",
                             bus.out_last, bus.out_data, stall_word[WORD_W], stall_word[WORD_W-1:0]);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                logic [WORD_W:0] e;
                tests++;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got last=%0b data=%h, required no word",
                             bus.out_last, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_last, bus.out_data} !== e) begin
                        fails++;
                        $display("FAIL sb_word: got last=%0b data=%h, required last=%0b data=%h",
                                 bus.out_last, bus.out_data, e[WORD_W], e[WORD_W-1:0]);
                    end
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_word = {bus.out_last, bus.out_data};
`ifdef ENTROPY_READER_REPEAT_CHK_EN
            if (repeat_drop) drop_cnt++;
`endif
        end
    end

    // Load a sample into the FIFO model and queue its first n_exp words
    task automatic push_sample(input logic [SAMPLE_SIZE-1:0] d, input int n_exp);
        fifo_q.push_back(d);
        for (int j = 0; j < n_exp; j++) begin
            logic [WORD_W-1:0] w;
            w = d[SAMPLE_SIZE-1-WORD_W*j -: WORD_W];
            exp_q.push_back({(j == NUM_WORDS - 1), w});
        end
    endtask

    task automatic rand_sample(output logic [SAMPLE_SIZE-1:0] d);
        for (int j = 0; j < int'(NUM_WORDS); j++) begin
            d[WORD_W*j +: WORD_W] = $urandom;
        end
    endtask

    // Wait until all expected words drained and the stream went idle
    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.src_valid = 1'b0;
        bus.src_perm_fail = 1'b0;
        bus.out_ready = 1'b0;
        bus.src_empty = 1'b1;
        bus.src_rdata = FILLER;
        repeat (3) @(negedge clk);
        tests++; if (bus.deque !== 1'b0) begin fails++; $display("FAIL rst_deque: got %b, required 0", bus.deque); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        tests++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last: got %b, required 0", bus.out_last); end
        tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL rst_out_data: got %h, required 0", bus.out_data); end
        tests++; if (lockout !== 1'b0) begin fails++; $display("FAIL rst_lockout: got %b, required 0", lockout); end
        tests++; if (sample_count !== '0) begin fails++; $display("FAIL rst_count: got %0d, required 0", sample_count); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [SAMPLE_SIZE-1:0] a;
        bit ok;
        int h0;
        int d0;
        a = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
             32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};
        h0 = hs_cnt;
        d0 = deq_cnt;
        push_sample(a, NUM_WORDS);
        bus.src_valid = 1'b1;
        bus.out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.deque) begin ok = 1'b1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL basic_deque: got no deque in 20 cycles, required one"); end
        if (ok) begin
            @(negedge clk);
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_lat1: out_valid=%b one cycle after deque, required 0", bus.out_valid); end
            @(negedge clk);
            tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_lat2: out_valid=%b two cycles after deque, required 1", bus.out_valid); end
        end
        wait_done(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_done: stream did not finish, %0d words left", exp_q.size()); end
        tests++; if (hs_cnt - h0 != NUM_WORDS) begin fails++; $display("FAIL basic_hs: got %0d handshakes, required %0d", hs_cnt - h0, NUM_WORDS); end
        tests++; if (deq_cnt - d0 != 1) begin fails++; $display("FAIL basic_deq: got %0d deques, required 1", deq_cnt - d0); end
        tests++; if (sample_count !== CNT_W'(1)) begin fails++; $display("FAIL basic_count: got %0d, required 1", sample_count); end
    endtask

    task automatic test_backpressure();
        logic [SAMPLE_SIZE-1:0] b;
        logic [3:0] pat;
        bit ok;
        int h0;
        pat = 4'b1001;
        rand_sample(b);
        h0 = hs_cnt;
        push_sample(b, NUM_WORDS);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            bus.out_ready = pat[k % 4];
            if (k > 4 && exp_q.size() == 0 && !bus.out_valid) begin ok = 1'b1; break; end
        end
        bus.out_ready = 1'b1;
        tests++; if (!ok) begin fails++; $display("FAIL bp_done: stream did not finish, %0d words left", exp_q.size()); end
        tests++; if (hs_cnt - h0 != NUM_WORDS) begin fails++; $display("FAIL bp_hs: got %0d handshakes, required %0d", hs_cnt - h0, NUM_WORDS); end
        tests++; if (sample_count !== CNT_W'(2)) begin fails++; $display("FAIL bp_count: got %0d, required 2", sample_count); end
    endtask

    task automatic test_empty_gating();
        logic [SAMPLE_SIZE-1:0] c;
        bit ok;
        int d0;
        bus.src_valid = 1'b1;
        d0 = deq_cnt;
        repeat (20) @(negedge clk);
        tests++; if (deq_cnt != d0) begin fails++; $display("FAIL empty_gate: got %0d deques while empty, required 0", deq_cnt - d0); end
        rand_sample(c);
        push_sample(c, NUM_WORDS);
        wait_done(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL empty_done: stream did not finish, %0d words left", exp_q.size()); end
        tests++; if (deq_cnt - d0 != 1) begin fails++; $display("FAIL empty_deq: got %0d deques, required 1", deq_cnt - d0); end
        tests++; if (sample_count !== CNT_W'(3)) begin fails++; $display("FAIL empty_count: got %0d, required 3", sample_count); end
    endtask

    task automatic test_perm_fail();
        logic [SAMPLE_SIZE-1:0] d;
        logic [SAMPLE_SIZE-1:0] e;
        bit ok;
        int h0;
        int d0;
        int bad;
        rand_sample(d);
        h0 = hs_cnt;
        push_sample(d, 3);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (hs_cnt - h0 == 3) begin ok = 1'b1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL pf_words: got %0d handshakes before fail, required 3", hs_cnt - h0); end
        bus.src_perm_fail = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (lockout !== 1'b1) begin fails++; $display("FAIL pf_lockout: got %b, required 1", lockout); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL pf_out_valid: got %b, required 0", bus.out_valid); end
        tests++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL pf_out_last: got %b, required 0", bus.out_last); end
        @(posedge clk); #1;
        bus.src_perm_fail = 1'b0;
        bus.out_ready = 1'b1;
        rand_sample(e);
        fifo_q.push_back(e);
        d0 = deq_cnt;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.out_valid || bus.deque) bad++;
        end
        tests++; if (deq_cnt != d0 || bad != 0) begin fails++; $display("FAIL pf_quiet: got %0d deques and %0d active cycles, required 0", deq_cnt - d0, bad); end
        tests++; if (lockout !== 1'b1) begin fails++; $display("FAIL pf_sticky: got lockout=%b after fail released, required 1", lockout); end
        tests++; if (sample_count !== CNT_W'(3)) begin fails++; $display("FAIL pf_count: got %0d, required 3", sample_count); end
        tests++; if (hs_cnt - h0 != 3) begin fails++; $display("FAIL pf_hs: got %0d handshakes, required 3", hs_cnt - h0); end
    endtask

    task automatic test_reset_midstream();
        logic [SAMPLE_SIZE-1:0] f;
        logic [SAMPLE_SIZE-1:0] g;
        bit ok;
        int h0;
        int d0;
        // Leave lockout first
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        bus.src_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.src_valid = 1'b1;
        rand_sample(f);
        h0 = hs_cnt;
        push_sample(f, NUM_WORDS);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (hs_cnt - h0 == 4) begin ok = 1'b1; break; end
        end
        tests++; if (!ok || bus.out_valid !== 1'b1) begin fails++; $display("FAIL rm_word5: got %0d handshakes out_valid=%b, required 4 and 1", hs_cnt - h0, bus.out_valid); end
        #2;
        rst = 1'b1;
        bus.src_valid = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rm_out_valid: got %b, required 0", bus.out_valid); end
        tests++; if (sample_count !== '0) begin fails++; $display("FAIL rm_count: got %0d, required 0", sample_count); end
        tests++; if (lockout !== 1'b0) begin fails++; $display("FAIL rm_lockout: got %b, required 0", lockout); end
        exp_q.delete();
        fifo_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.src_valid = 1'b1;
        rand_sample(g);
        h0 = hs_cnt;
        d0 = deq_cnt;
        push_sample(g, NUM_WORDS);
        wait_done(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rm_done: stream did not finish, %0d words left", exp_q.size()); end
        tests++; if (deq_cnt - d0 != 1) begin fails++; $display("FAIL rm_deq: got %0d deques after release, required 1", deq_cnt - d0); end
        tests++; if (hs_cnt - h0 != NUM_WORDS) begin fails++; $display("FAIL rm_hs: got %0d handshakes, required %0d", hs_cnt - h0, NUM_WORDS); end
        tests++; if (sample_count !== CNT_W'(1)) begin fails++; $display("FAIL rm_count_after: got %0d, required 1", sample_count); end
    endtask

`ifdef ENTROPY_READER_REPEAT_CHK_EN
    task automatic test_repeat();
        logic [SAMPLE_SIZE-1:0] x;
        logic [SAMPLE_SIZE-1:0] y;
        bit ok;
        int d0;
        int r0;
        rand_sample(x);
        push_sample(x, NUM_WORDS);
        wait_done(100, ok);
        tests++; if (!ok || sample_count !== CNT_W'(2)) begin fails++; $display("FAIL rep_first: done=%0b count=%0d, required 1 and 2", ok, sample_count); end
        d0 = deq_cnt;
        r0 = drop_cnt;
        push_sample(x, 0);
        repeat (15) @(negedge clk);
        tests++; if (deq_cnt - d0 != 1) begin fails++; $display("FAIL rep_deq: got %0d deques, required 1", deq_cnt - d0); end
        tests++; if (drop_cnt - r0 != 1) begin fails++; $display("FAIL rep_drop: got %0d drop pulses, required 1", drop_cnt - r0); end
        tests++; if (sample_count !== CNT_W'(2)) begin fails++; $display("FAIL rep_count: got %0d, required 2", sample_count); end
        rand_sample(y);
        push_sample(y, NUM_WORDS);
        wait_done(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rep_third: stream did not finish, %0d words left", exp_q.size()); end
        tests++; if (sample_count !== CNT_W'(3)) begin fails++; $display("FAIL rep_count3: got %0d, required 3", sample_count); end
        tests++; if (drop_cnt - r0 != 1) begin fails++; $display("FAIL rep_nodrop: got %0d drop pulses, required 1", drop_cnt - r0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_gating();
        test_perm_fail();
        test_reset_midstream();
`ifdef ENTROPY_READER_REPEAT_CHK_EN
        test_repeat();
`endif
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
